// File: rtl/kb_event_fifo.sv
// PS/2 scan-code decoder with E0/F0 prefix handling, repeat filter
// and a first-word-fall-through event buffer.
module kb_event_fifo #(
    parameter int W_SIZE          = 2,
    parameter bit REPORT_MAKE     = 1'b1,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    input  logic       rd_key_code,
    input  logic       clr_ovf,
    output logic [9:0] key_event,
    output logic       kb_buf_empty,
    output logic       kb_buf_full,
    output logic       kb_overflow
);
    localparam int DEPTH = 1 << W_SIZE;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t state, state_next;
    logic   ev_valid, ev_ext, ev_brk;
    logic   discard;

    always_comb begin
        discard = scan_code inside {8'h00, 8'hAA, 8'hE1, 8'hEE,
                                    8'hFA, 8'hFE, 8'hFF};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ev_valid   = 1'b0;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        if (scan_done_tick) begin
            unique case (state)
                IDLE: begin
                    if (scan_code == 8'hE0)      state_next = EXT;
                    else if (scan_code == 8'hF0) state_next = BRK;
                    else if (!discard)           ev_valid   = 1'b1;
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_next = EXT_BRK;
                    end else if (scan_code != 8'hE0) begin
                        ev_valid   = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    ev_valid   = 1'b1;
                    ev_brk     = 1'b1;
                    state_next = IDLE;
                end
                EXT_BRK: begin
                    ev_valid   = 1'b1;
                    ev_ext     = 1'b1;
                    ev_brk     = 1'b1;
                    state_next = IDLE;
                end
            endcase
        end
    end

    logic [8:0] ev_key, last_make;
    logic       lm_valid, lm_hit, push_req;

    assign ev_key   = {ev_ext, scan_code};
    assign lm_hit   = SUPPRESS_REPEAT && lm_valid && (last_make == ev_key);
    assign push_req = ev_valid && (ev_brk || (REPORT_MAKE && !lm_hit));

    // Repeat tracking runs regardless of whether makes are reported.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lm_valid  <= 1'b0;
            last_make <= '0;
        end else if (ev_valid && SUPPRESS_REPEAT) begin
            if (!ev_brk && !lm_hit) begin
                lm_valid  <= 1'b1;
                last_make <= ev_key;
            end else if (ev_brk && lm_hit) begin
                lm_valid  <= 1'b0;
            end
        end
    end

    logic [9:0]        mem [DEPTH];
    logic [W_SIZE-1:0] wr_ptr, rd_ptr, wr_succ, rd_succ;
    logic              push, pop;

    assign pop       = rd_key_code && !kb_buf_empty;
    assign push      = push_req && (!kb_buf_full || rd_key_code);
    assign wr_succ   = wr_ptr + 1'b1;
    assign rd_succ   = rd_ptr + 1'b1;
    assign key_event = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ev_ext, ev_brk, scan_code};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            kb_buf_empty <= 1'b1;
            kb_buf_full  <= 1'b0;
            kb_overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_succ;
            if (pop)  rd_ptr <= rd_succ;
            if (push && !pop) begin
                kb_buf_empty <= 1'b0;
                kb_buf_full  <= (wr_succ == rd_ptr);
            end else if (pop && !push) begin
                kb_buf_full  <= 1'b0;
                kb_buf_empty <= (rd_succ == wr_ptr);
            end
            // A fresh overflow beats a simultaneous clear.
            if (push_req && kb_buf_full && !rd_key_code) kb_overflow <= 1'b1;
            else if (clr_ovf)                           kb_overflow <= 1'b0;
        end
    end

endmodule
